// File: rtl/seg_scan_display.sv
// Four-digit multiplexed hex display of an ALU result byte and a count
// of how many times that displayed byte has changed.
module seg_scan_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_result,
    input  logic       freeze,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] rcnt;
    logic [1:0]    idx;
    logic [7:0]    shown_value;
    logic [7:0]    change_cnt;
    logic          tick;
    logic          load;
    logic [3:0]    nib;
    logic [6:0]    seg_next;

    assign tick = (rcnt == LAST);
    assign load = !freeze && (alu_result != shown_value);

    always_comb begin
        nib = 4'h0;
        unique case (idx)
            2'd0: nib = shown_value[3:0];
            2'd1: nib = shown_value[7:4];
            2'd2: nib = change_cnt[3:0];
            2'd3: nib = change_cnt[7:4];
        endcase
    end

    // segment order {g,f,e,d,c,b,a}, active-low
    always_comb begin
        seg_next = 7'b1111111;
        unique case (nib)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'ha: seg_next = 7'b0001000;
            4'hb: seg_next = 7'b0000011;
            4'hc: seg_next = 7'b1000110;
            4'hd: seg_next = 7'b0100001;
            4'he: seg_next = 7'b0000110;
            4'hf: seg_next = 7'b0001110;
        endcase
    end

    // outputs sample pre-update state, so a load shows up one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt        <= '0;
            idx         <= 2'd0;
            shown_value <= 8'h00;
            change_cnt  <= 8'h00;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
        end else begin
            rcnt <= tick ? '0 : rcnt + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
            if (load) begin
                shown_value <= alu_result;
                change_cnt  <= change_cnt + 8'd1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
            dp  <= ~((idx == 2'd0) && freeze);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a 4-cycle digit slot.
module tb_seg_scan_display;

    logic       clk;
    logic       reset;
    logic [7:0] alu_result;
    logic       freeze;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_chk;
    int n_pass;
    int edges;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] SA = 7'b0001000;

    typedef struct {
        logic [7:0] val;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [6:0] s3;
    } vec_t;

    vec_t vecs[10];

    seg_scan_display #(.REFRESH_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .alu_result(alu_result),
        .freeze(freeze),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     nm, act, exp, edges);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic do_reset(input logic [7:0] v);
        @(posedge clk);
        #2;
        reset = 1'b1;
        alu_result = v;
        freeze = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        edges = 0;
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        while (an !== target && n < 24) begin
            step();
            n++;
        end
        chk("wait_an", {4'h0, an}, {4'h0, target});
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] ea;
        int d;
        one = 4'b0001;
        n_chk = 0;
        n_pass = 0;
        edges = 0;
        clk = 1'b0;
        reset = 1'b1;
        alu_result = 8'h00;
        freeze = 1'b0;

        vecs[0] = '{8'h00, S0, S0, S0, S0};
        vecs[1] = '{8'h3A, SA, S3, S1, S0};
        vecs[2] = '{8'h10, S0, S1, S1, S0};
        vecs[3] = '{8'h32, S2, S3, S1, S0};
        vecs[4] = '{8'h54, 7'b0011001, 7'b0010010, S1, S0};
        vecs[5] = '{8'h76, 7'b0000010, 7'b1111000, S1, S0};
        vecs[6] = '{8'h98, 7'b0000000, 7'b0010000, S1, S0};
        vecs[7] = '{8'hBA, SA, 7'b0000011, S1, S0};
        vecs[8] = '{8'hDC, 7'b1000110, 7'b0100001, S1, S0};
        vecs[9] = '{8'hFE, 7'b0000110, 7'b0001110, S1, S0};

        #3;
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp", {7'h0, dp}, 8'h01);

        // full scan order and blank value after release
        do_reset(8'h00);
        for (int k = 1; k <= 17; k++) begin
            step();
            d = ((k - 1) / 4) % 4;
            ea = ~(one << d);
            chk("scan_an", {4'h0, an}, {4'h0, ea});
            chk("scan_seg", {1'b0, seg}, {1'b0, S0});
        end

        for (int i = 0; i < 10; i++) begin
            do_reset(vecs[i].val);
            for (int k = 1; k <= 16; k++) begin
                step();
                if (k == 4) begin
                    chk("vec_an0", {4'h0, an}, 8'h0E);
                    chk("vec_d0", {1'b0, seg}, {1'b0, vecs[i].s0});
                    chk("vec_dp", {7'h0, dp}, 8'h01);
                end
                if (k == 8) begin
                    chk("vec_an1", {4'h0, an}, 8'h0D);
                    chk("vec_d1", {1'b0, seg}, {1'b0, vecs[i].s1});
                end
                if (k == 12) begin
                    chk("vec_an2", {4'h0, an}, 8'h0B);
                    chk("vec_d2", {1'b0, seg}, {1'b0, vecs[i].s2});
                end
                if (k == 16) begin
                    chk("vec_an3", {4'h0, an}, 8'h07);
                    chk("vec_d3", {1'b0, seg}, {1'b0, vecs[i].s3});
                end
            end
        end

        // load shows one cycle after the edge that captures it
        do_reset(8'h00);
        step();
        alu_result = 8'h3A;
        step();
        chk("lat_old", {1'b0, seg}, {1'b0, S0});
        step();
        chk("lat_new", {1'b0, seg}, {1'b0, SA});

        // change lands on the tick edge
        do_reset(8'h00);
        step();
        step();
        step();
        alu_result = 8'h3A;
        step();
        chk("tick_an", {4'h0, an}, 8'h0E);
        chk("tick_old", {1'b0, seg}, {1'b0, S0});
        step();
        chk("tick_an1", {4'h0, an}, 8'h0D);
        chk("tick_new", {1'b0, seg}, {1'b0, S3});
        wait_an(4'b1011);
        chk("tick_cnt", {1'b0, seg}, {1'b0, S1});

        // 256 differing values wrap the change count
        do_reset(8'h00);
        for (int i = 0; i < 256; i++) begin
            alu_result = 8'(i + 1);
            step();
        end
        wait_an(4'b1011);
        chk("wrap_lo", {1'b0, seg}, {1'b0, S0});
        wait_an(4'b0111);
        chk("wrap_hi", {1'b0, seg}, {1'b0, S0});
        wait_an(4'b1110);
        chk("wrap_val", {1'b0, seg}, {1'b0, S0});
        alu_result = 8'h05;
        wait_an(4'b1011);
        chk("wrap_inc", {1'b0, seg}, {1'b0, S1});

        // freeze holds value and count, lights dp on digit 0
        do_reset(8'h3A);
        for (int k = 0; k < 4; k++)
            step();
        freeze = 1'b1;
        for (int i = 0; i < 50; i++) begin
            alu_result = (i % 2 == 0) ? 8'h11 : 8'h22;
            step();
            if (an === 4'b1110) begin
                chk("frz_dp0", {7'h0, dp}, 8'h00);
                chk("frz_seg0", {1'b0, seg}, {1'b0, SA});
            end else begin
                chk("frz_dp1", {7'h0, dp}, 8'h01);
            end
        end
        alu_result = 8'h22;
        wait_an(4'b1101);
        chk("frz_hi", {1'b0, seg}, {1'b0, S3});
        wait_an(4'b1011);
        chk("frz_cnt", {1'b0, seg}, {1'b0, S1});
        freeze = 1'b0;
        wait_an(4'b1110);
        chk("rel_val", {1'b0, seg}, {1'b0, S2});
        chk("rel_dp", {7'h0, dp}, 8'h01);
        wait_an(4'b1011);
        chk("rel_cnt", {1'b0, seg}, {1'b0, S2});
        wait_an(4'b0111);
        chk("rel_cnth", {1'b0, seg}, {1'b0, S0});

        // asynchronous reset in the middle of digit 2
        do_reset(8'h3A);
        wait_an(4'b1011);
        #2;
        reset = 1'b1;
        alu_result = 8'h00;
        #1;
        chk("arst_an", {4'h0, an}, 8'h0F);
        chk("arst_seg", {1'b0, seg}, 8'h7F);
        chk("arst_dp", {7'h0, dp}, 8'h01);
        step();
        chk("arst_hold", {4'h0, an}, 8'h0F);
        #2;
        reset = 1'b0;
        edges = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                chk("post_an", {4'h0, an}, 8'h0E);
                chk("post_seg", {1'b0, seg}, {1'b0, S0});
            end
            if (k == 4)
                chk("post_an4", {4'h0, an}, 8'h0E);
            if (k == 5)
                chk("post_an5", {4'h0, an}, 8'h0D);
        end
        wait_an(4'b1011);
        chk("post_cnt", {1'b0, seg}, {1'b0, S0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, default 100000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: alu_result  input  8  processor ALU result byte to display.
REQ-005 SHALL have port: freeze  input  1  1 = hold displayed value and change count.
REQ-006 SHALL have port: an  output  4  digit anodes, active-low, an[0] = rightmost digit.
REQ-007 SHALL have port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port: dp  output  1  decimal point, active-low.

Function
REQ-009 SHALL hold shown_value[7:0] and change_cnt[7:0], both 0 after reset.
REQ-010 SHALL, on each clk with freeze=0 and alu_result != shown_value: load shown_value <= alu_result and set change_cnt <= change_cnt+1, modulo 256 (255 -> 0).
REQ-011 SHALL leave shown_value and change_cnt unchanged while freeze=1. On release, one differing value SHALL produce exactly one increment.
REQ-012 SHALL have a refresh counter that counts 0..REFRESH_DIV-1 and then wraps to 0. The wrap cycle is the tick.
REQ-013 SHALL have a 2-bit digit index that advances 0->1->2->3->0 on each tick only.
REQ-014 SHALL map digits as: index 0 = shown_value[3:0], 1 = shown_value[7:4], 2 = change_cnt[3:0], 3 = change_cnt[7:4].
REQ-015 SHALL drive low only the an bit equal to the digit index. The other three an bits SHALL be 1.
REQ-016 SHALL decode hex nibbles active-low as:
 - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
 - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
REQ-017 SHALL drive dp=0 only when the digit index is 0 and freeze=1. Otherwise dp=1.
REQ-018 SHALL register an, seg and dp. They SHALL reflect the digit index, shown_value, change_cnt and freeze as they were at the previous clk edge (1-cycle latency).
REQ-019 SHALL register seg from pre-update shown_value/change_cnt when an update and a register load occur on the same edge. The new value SHALL appear one cycle later.
REQ-020 SHALL have a tick plus a value change on the same edge take effect independently: the digit advances and the count increments.
REQ-021 SHALL have no combinational path from any input to any output.

Reset
REQ-022 SHALL, while reset=1 and regardless of clk, force:
 - an=1111, seg=1111111, dp=1
 - refresh counter=0, digit index=0
 - shown_value=0, change_cnt=0
REQ-023 SHALL have the first clk edge after reset deassertion load an=1110 and seg=1000000.
REQ-024 SHALL, on a reset asserted mid-scan or mid-freeze, return all state to REQ-022 values immediately. There SHALL be no retained partial count.

Verification (bench uses REFRESH_DIV=4)
REQ-025 SHALL cover: reset, alu_result=0x00, freeze=0 -> change_cnt stays 0. After release, an sequence is 1110, 1101, 1011, 0111, each held 4 cycles, seg=1000000 on every digit.
REQ-026 SHALL cover: alu_result=0x3A held -> change_cnt=1. Digits 0..3 show A (0001000), 3 (0110000), 1 (1111001), 0 (1000000).
REQ-027 SHALL cover: 256 successive differing values with freeze=0 -> change_cnt wraps to 0x00 and displays 0,0 on digits 2,3.
REQ-028 SHALL cover: freeze=1, alu_result toggled 0x11/0x22 for 50 cycles -> shown_value and change_cnt unchanged, dp=0 while digit 0 is active. After freeze=0 with alu_result=0x22 -> exactly +1.
REQ-029 SHALL cover: reset pulsed asynchronously between clk edges during digit 2 -> an=1111, seg=1111111, dp=1 within the same cycle. All counters read 0 after release.
REQ-030 SHALL cover: alu_result change on the tick edge -> digit advances and seg shows the old value for 1 cycle, then the new value (REQ-019).
